// File: rtl/tt_tile_if.sv
// tt_tile_if -- bundle of the tile-select controls, user-design data paths and
// user-design control outputs between the tile sequencer and its surroundings.
//   master : drives select controls, pad inputs and user outputs; observes the rest
//   slave  : the tile sequencer (tt_tile_seq)
interface tt_tile_if;
  logic       sel_inc;         // increment address counter
  logic       sel_clr;         // synchronous clear of address counter
  logic       sel_load;        // commit counter match into the select flag
  logic       user_rst_req_n;  // external user reset request, active-low
  logic [7:0] ui_pad;          // dedicated input pins
  logic [7:0] uio_pad;         // bidirectional input path from pins
  logic [7:0] uo_user;         // user design dedicated outputs
  logic [7:0] ui_in;           // gated dedicated inputs to the user design
  logic [7:0] uio_in;          // gated bidirectional inputs to the user design
  logic [7:0] uo_pad;          // gated user outputs to pins
  logic       ena;             // user design enable
  logic       clk_en;          // user clock-gate enable
  logic       rst_n;           // user design reset, active-low
  logic       busy;            // sequencer not idle

  modport master (
    output sel_inc, sel_clr, sel_load, user_rst_req_n, ui_pad, uio_pad, uo_user,
    input  ui_in, uio_in, uo_pad, ena, clk_en, rst_n, busy
  );

  modport slave (
    input  sel_inc, sel_clr, sel_load, user_rst_req_n, ui_pad, uio_pad, uo_user,
    output ui_in, uio_in, uo_pad, ena, clk_en, rst_n, busy
  );
endinterface

// File: rtl/tt_tile_seq.sv
// tt_tile_seq -- per-tile select and power-up sequencer.
// An address counter is stepped by sel_inc/sel_clr; sel_load latches whether the
// counter matches MY_ADDR. A Moore FSM (IDLE/RESET/RUN/STOP) then enables the
// user design, holds it in reset for RST_CYCLES cycles, passes data while in RUN
// and spends one STOP cycle with the clock gated on deselection.
// Ports:
//   clk  - single clock
//   rst  - asynchronous active-high reset
//   bus  - tt_tile_if.slave (select controls, data paths, user control outputs)
module tt_tile_seq #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned MY_ADDR    = 0,
  parameter int unsigned RST_CYCLES = 4   // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst,
  tt_tile_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] MY_ADDR_C = ADDR_W'(MY_ADDR);
  localparam logic [3:0]        RST_LAST  = 4'(RST_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic [3:0]        rcnt_q, rcnt_d;

  logic       ena_q, ena_d;
  logic       clk_en_q, clk_en_d;
  logic       rst_n_q, rst_n_d;
  logic       busy_q, busy_d;
  logic [7:0] ui_in_q, ui_in_d;
  logic [7:0] uio_in_q, uio_in_d;
  logic [7:0] uo_pad_q, uo_pad_d;

  // Address counter and select flag. The match is taken on the counter value
  // before any same-cycle clear or increment.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cnt_d = cnt_q;
    if (bus.sel_clr) begin
      cnt_d = '0;
    end else if (bus.sel_inc) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end
    sel_d = bus.sel_load ? (cnt_q == MY_ADDR_C) : sel_q;
  end

  // Next-state logic. Deselection beats RESET->RUN; rcnt counts completed
  // RESET cycles and is cleared on the only entry path (IDLE->RESET).
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (sel_q) begin
          state_d = S_RESET;
          rcnt_d  = '0;
        end
      end
      S_RESET: begin
        if (!sel_q) begin
          state_d = S_STOP;
        end else if (rcnt_q == RST_LAST) begin
          state_d = S_RUN;
        end else begin
          rcnt_d = rcnt_q + 4'd1;
        end
      end
      S_RUN: begin
        if (!sel_q) state_d = S_STOP;
      end
      S_STOP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state, so registered outputs change on the
  // same edge as the state register.
  always_comb begin
    ena_d    = 1'b0;
    clk_en_d = 1'b0;
    rst_n_d  = 1'b0;
    ui_in_d  = '0;
    uio_in_d = '0;
    uo_pad_d = '0;
    busy_d   = (state_d != S_IDLE);
    unique case (state_d)
      S_RESET: begin
        ena_d    = 1'b1;
        clk_en_d = 1'b1;
      end
      S_RUN: begin
        ena_d    = 1'b1;
        clk_en_d = 1'b1;
        rst_n_d  = bus.user_rst_req_n;  // only honoured in RUN
        ui_in_d  = bus.ui_pad;
        uio_in_d = bus.uio_pad;
        uo_pad_d = bus.uo_user;
      end
      S_STOP:  ena_d = 1'b1;
      default: ;
    endcase
  end

  // State register: async reset forces every output low immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      rcnt_q   <= '0;
      ena_q    <= 1'b0;
      clk_en_q <= 1'b0;
      rst_n_q  <= 1'b0;
      busy_q   <= 1'b0;
      ui_in_q  <= '0;
      uio_in_q <= '0;
      uo_pad_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      rcnt_q   <= rcnt_d;
      ena_q    <= ena_d;
      clk_en_q <= clk_en_d;
      rst_n_q  <= rst_n_d;
      busy_q   <= busy_d;
      ui_in_q  <= ui_in_d;
      uio_in_q <= uio_in_d;
      uo_pad_q <= uo_pad_d;
    end
  end

  assign bus.ena    = ena_q;
  assign bus.clk_en = clk_en_q;
  assign bus.rst_n  = rst_n_q;
  assign bus.busy   = busy_q;
  assign bus.ui_in  = ui_in_q;
  assign bus.uio_in = uio_in_q;
  assign bus.uo_pad = uo_pad_q;

endmodule

// File: tb/tb_tt_tile_seq.sv
module tb_tt_tile_seq;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  tt_tile_if bus ();

  tt_tile_seq #(
    .ADDR_W     (5),
    .MY_ADDR    (3),
    .RST_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic e_ena, input logic e_clk_en,
                           input logic e_rst_n, input logic e_busy);
    check({tag, "_ena"},    32'(bus.ena),    32'(e_ena));
    check({tag, "_clk_en"}, 32'(bus.clk_en), 32'(e_clk_en));
    check({tag, "_rst_n"},  32'(bus.rst_n),  32'(e_rst_n));
    check({tag, "_busy"},   32'(bus.busy),   32'(e_busy));
  endtask

  initial begin
    bus.sel_inc        = 1'b0;
    bus.sel_clr        = 1'b0;
    bus.sel_load       = 1'b0;
    bus.user_rst_req_n = 1'b1;
    bus.ui_pad         = 8'h00;
    bus.uio_pad        = 8'h00;
    bus.uo_user        = 8'h00;
    rst                = 1'b1;

    // Reset state
    tick(); tick();
    check_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_ui_in",  32'(bus.ui_in),  32'h0);
    check("rst_uio_in", 32'(bus.uio_in), 32'h0);
    check("rst_uo_pad", 32'(bus.uo_pad), 32'h0);
    check("rst_cnt",    32'(dut.cnt_q),  32'd0);
    check("rst_sel",    32'(dut.sel_q),  32'd0);
    rst = 1'b0;
    tick();
    check_ctl("post_rst_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Select: 3 increments, load
    bus.sel_inc = 1'b1;
    repeat (3) tick();
    bus.sel_inc = 1'b0;
    check("cnt_3", 32'(dut.cnt_q), 32'd3);
    bus.sel_load = 1'b1;
    tick();
    bus.sel_load = 1'b0;
    check("sel_set", 32'(dut.sel_q), 32'd1);
    check("load_edge_ena", 32'(bus.ena), 32'd0);
    bus.ui_pad  = 8'hA5;
    bus.uio_pad = 8'h5A;
    bus.uo_user = 8'hC3;
    tick();
    check_ctl("reset_c1", 1'b1, 1'b1, 1'b0, 1'b1);
    check("reset_c1_ui_in",  32'(bus.ui_in),  32'h0);
    check("reset_c1_uo_pad", 32'(bus.uo_pad), 32'h0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      check_ctl($sformatf("reset_c%0d", i), 1'b1, 1'b1, 1'b0, 1'b1);
    end
    tick();
    check_ctl("run_entry", 1'b1, 1'b1, 1'b1, 1'b1);
    check("run_ui_in",  32'(bus.ui_in),  32'hA5);
    check("run_uio_in", 32'(bus.uio_in), 32'h5A);
    check("run_uo_pad", 32'(bus.uo_pad), 32'hC3);
    bus.ui_pad = 8'h3C;
    #1;
    check("ui_in_before_edge", 32'(bus.ui_in), 32'hA5);
    tick();
    check("ui_in_after_edge", 32'(bus.ui_in), 32'h3C);
    bus.user_rst_req_n = 1'b0;
    tick();
    check_ctl("run_user_rst", 1'b1, 1'b1, 1'b0, 1'b1);
    bus.user_rst_req_n = 1'b1;
    tick();
    check("run_user_rst_release", 32'(bus.rst_n), 32'd1);

    // Deselect from RUN
    bus.sel_clr = 1'b1;
    tick();
    bus.sel_clr = 1'b0;
    check("clr_cnt", 32'(dut.cnt_q), 32'd0);
    bus.sel_inc = 1'b1;
    repeat (5) tick();
    bus.sel_inc = 1'b0;
    check("cnt_5", 32'(dut.cnt_q), 32'd5);
    bus.uo_user  = 8'hFF;
    bus.sel_load = 1'b1;
    tick();
    bus.sel_load = 1'b0;
    check("sel_clear", 32'(dut.sel_q), 32'd0);
    check("run_last_uo_pad", 32'(bus.uo_pad), 32'hFF);
    tick();
    check_ctl("stop", 1'b1, 1'b0, 1'b0, 1'b1);
    check("stop_uo_pad", 32'(bus.uo_pad), 32'h00);
    tick();
    check_ctl("idle_after_stop", 1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_uo_pad", 32'(bus.uo_pad), 32'h00);
    tick();
    check("idle_stays", 32'(bus.busy), 32'd0);

    // Wrap: 35 increments from 0 -> 3
    bus.sel_clr = 1'b1;
    tick();
    bus.sel_clr = 1'b0;
    bus.sel_inc = 1'b1;
    repeat (35) tick();
    bus.sel_inc = 1'b0;
    check("cnt_wrap", 32'(dut.cnt_q), 32'd3);

    // Load with clear in same cycle: samples 3 -> selected, counter -> 0
    bus.sel_load = 1'b1;
    bus.sel_clr  = 1'b1;
    tick();
    bus.sel_load = 1'b0;
    bus.sel_clr  = 1'b0;
    check("wrap_sel", 32'(dut.sel_q), 32'd1);
    check("load_clr_cnt", 32'(dut.cnt_q), 32'd0);
    bus.sel_inc = 1'b1;
    tick();  // RESET cycle 1, cnt 1
    check_ctl("dsel_reset_c1", 1'b1, 1'b1, 1'b0, 1'b1);
    check("dsel_cnt1", 32'(dut.cnt_q), 32'd1);
    bus.sel_load       = 1'b1;
    bus.user_rst_req_n = 1'b0;
    tick();  // RESET cycle 2, deselected (sampled 1), cnt 2
    bus.sel_load = 1'b0;
    check("dsel_sel", 32'(dut.sel_q), 32'd0);
    check_ctl("dsel_reset_c2", 1'b1, 1'b1, 1'b0, 1'b1);
    check("dsel_c2_ui_in", 32'(bus.ui_in), 32'h0);
    tick();  // STOP, cnt 3
    check_ctl("dsel_stop", 1'b1, 1'b0, 1'b0, 1'b1);
    check("dsel_stop_ui_in", 32'(bus.ui_in), 32'h0);
    check("dsel_cnt3", 32'(dut.cnt_q), 32'd3);
    bus.sel_inc  = 1'b0;
    bus.sel_load = 1'b1;
    tick();  // IDLE despite reselection
    bus.sel_load = 1'b0;
    check_ctl("resel_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check("resel_sel", 32'(dut.sel_q), 32'd1);
    tick();
    check_ctl("resel_reset_c1", 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      check_ctl($sformatf("resel_reset_c%0d", i), 1'b1, 1'b1, 1'b0, 1'b1);
    end
    bus.user_rst_req_n = 1'b1;
    tick();
    check_ctl("resel_run", 1'b1, 1'b1, 1'b1, 1'b1);
    check("resel_run_ui_in", 32'(bus.ui_in), 32'h3C);

    // Clear beats increment; load samples 7
    bus.sel_inc = 1'b1;
    repeat (4) tick();
    bus.sel_inc = 1'b0;
    check("cnt_7", 32'(dut.cnt_q), 32'd7);
    bus.sel_clr  = 1'b1;
    bus.sel_inc  = 1'b1;
    bus.sel_load = 1'b1;
    tick();
    bus.sel_clr  = 1'b0;
    bus.sel_inc  = 1'b0;
    bus.sel_load = 1'b0;
    check("clr_wins_cnt", 32'(dut.cnt_q), 32'd0);
    check("sample7_sel", 32'(dut.sel_q), 32'd0);
    tick();
    check_ctl("clr_stop", 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    check_ctl("clr_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Async reset mid-RUN
    bus.sel_inc = 1'b1;
    repeat (3) tick();
    bus.sel_inc  = 1'b0;
    bus.sel_load = 1'b1;
    tick();
    bus.sel_load = 1'b0;
    repeat (5) tick();
    check_ctl("pre_arst_run", 1'b1, 1'b1, 1'b1, 1'b1);
    check("pre_arst_ui_in", 32'(bus.ui_in), 32'h3C);
    #2;
    rst = 1'b1;
    #1;
    check_ctl("arst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("arst_ui_in",  32'(bus.ui_in),  32'h0);
    check("arst_uio_in", 32'(bus.uio_in), 32'h0);
    check("arst_uo_pad", 32'(bus.uo_pad), 32'h0);
    check("arst_cnt",    32'(dut.cnt_q),  32'd0);
    check("arst_sel",    32'(dut.sel_q),  32'd0);
    rst = 1'b0;
    tick();
    check_ctl("arst_release_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
